// File: rtl/reg_file_pkg.sv
// Shared types and constants for the register-file scoreboard.
package reg_file_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REGISTER_X0 = '0;

  typedef enum logic [1:0] {
    STALL_NONE = 2'd0,
    STALL_RAW  = 2'd1,
    STALL_WAW  = 2'd2,
    STALL_FULL = 2'd3
  } scoreboard_stall_t;

  // One-hot register mask for an address
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Decode-issue and writeback bus between the pipeline and the scoreboard.
interface reg_file_scoreboard_if;
  import reg_file_pkg::*;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_uses_rs1;
  logic                  issue_uses_rs2;
  logic                  issue_writes_rd;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
           wb_valid, wb_rd,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
           wb_valid, wb_rd,
    output issue_ready
  );

endinterface

// File: rtl/scoreboard_hazard_check.sv
// Combinational RAW/WAW/FULL hazard evaluation and stall-cause encoding.
module scoreboard_hazard_check
  import reg_file_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  issue_valid,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_uses_rs1,
  input  logic                  issue_uses_rs2,
  input  logic                  issue_writes_rd,
  input  logic [NUM_REGS-1:0]   busy_vec,
  input  logic [CNT_W-1:0]      outstanding,
  output logic                  issue_ready,
  output scoreboard_stall_t     stall_cause
);

  logic raw;
  logic waw;
  logic full;

  // x0 is never busy, so it can never raise RAW/WAW; FULL excludes it explicitly
  always_comb begin
    raw  = (issue_uses_rs1 && busy_vec[issue_rs1]) ||
           (issue_uses_rs2 && busy_vec[issue_rs2]);
    waw  = issue_writes_rd && busy_vec[issue_rd];
    full = issue_writes_rd && (issue_rd != REGISTER_X0) &&
           (outstanding == CNT_W'(MAX_OUTSTANDING));

    issue_ready = !(flush || raw || waw || full);
    stall_cause = STALL_NONE;
    if (issue_valid && !issue_ready) begin
      if (full)     stall_cause = STALL_FULL;
      else if (raw) stall_cause = STALL_RAW;
      else if (waw) stall_cause = STALL_WAW;
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register-file pending-write scoreboard with issue gating and sticky writeback error.
// Define REG_FILE_SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback release hazards.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  reg_file_scoreboard_if.slave                   bus,
  input  logic                                   flush,
  output logic [NUM_REGS-1:0]                    busy_vec,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output scoreboard_stall_t                      stall_cause,
  output logic                                   wb_err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                wb_hit;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] chk_busy;
  logic [CNT_W-1:0]    chk_cnt;
  logic                accept;
  logic                set_en;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                err_d;

  // Writeback only clears a register that is actually pending
  always_comb begin
    wb_hit  = bus.wb_valid && busy_vec[bus.wb_rd];
    wb_mask = wb_hit ? reg_onehot(bus.wb_rd) : '0;
  end

`ifdef REG_FILE_SCOREBOARD_WB_BYPASS_EN
  assign chk_busy = busy_vec & ~wb_mask;
  assign chk_cnt  = outstanding - CNT_W'(wb_hit);
`else
  assign chk_busy = busy_vec;
  assign chk_cnt  = outstanding;
`endif

  scoreboard_hazard_check #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_hazard (
    .issue_valid     (bus.issue_valid),
    .flush           (flush),
    .issue_rs1       (bus.issue_rs1),
    .issue_rs2       (bus.issue_rs2),
    .issue_rd        (bus.issue_rd),
    .issue_uses_rs1  (bus.issue_uses_rs1),
    .issue_uses_rs2  (bus.issue_uses_rs2),
    .issue_writes_rd (bus.issue_writes_rd),
    .busy_vec        (chk_busy),
    .outstanding     (chk_cnt),
    .issue_ready     (bus.issue_ready),
    .stall_cause     (stall_cause)
  );

  // Clear before set so a bypassed same-register reissue stays busy
  always_comb begin
    busy_d   = busy_vec;
    cnt_d    = outstanding;
    accept   = bus.issue_valid && bus.issue_ready;
    set_en   = accept && bus.issue_writes_rd && (bus.issue_rd != REGISTER_X0);
    set_mask = set_en ? reg_onehot(bus.issue_rd) : '0;
    err_d    = wb_err || (bus.wb_valid && !wb_hit);
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      busy_d    = (busy_vec & ~wb_mask) | set_mask;
      busy_d[0] = 1'b0;
      cnt_d     = outstanding + CNT_W'(set_en) - CNT_W'(wb_hit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec    <= '0;
      outstanding <= '0;
      wb_err      <= 1'b0;
    end else begin
      busy_vec    <= busy_d;
      outstanding <= cnt_d;
      wb_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard-style bench for reg_file_scoreboard: directed stimulus queues expected state per cycle.
module tb_reg_file_scoreboard;
  import reg_file_pkg::*;

  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0]    outstanding;
  scoreboard_stall_t   stall_cause;
  logic                wb_err;

  reg_file_scoreboard_if bus();

  reg_file_scoreboard #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .busy_vec    (busy_vec),
    .outstanding (outstanding),
    .stall_cause (stall_cause),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    string             name;
    logic              ready;
    scoreboard_stall_t stall;
    logic [31:0]       busy;
    int unsigned       outst;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: pop every expectation due this cycle and compare against the DUT
  always @(negedge clk) begin
    chk("popcount_invariant", 32'(outstanding), 32'($countones(busy_vec)));
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc < cyc) begin
        chk({mon_e.name, ".missed"}, 32'(cyc), 32'(mon_e.cyc));
      end else begin
        chk({mon_e.name, ".ready"},       32'(bus.issue_ready), 32'(mon_e.ready));
        chk({mon_e.name, ".stall"},       32'(stall_cause),     32'(mon_e.stall));
        chk({mon_e.name, ".busy_vec"},    busy_vec,             mon_e.busy);
        chk({mon_e.name, ".outstanding"}, 32'(outstanding),     32'(mon_e.outst));
        chk({mon_e.name, ".wb_err"},      32'(wb_err),          32'(mon_e.err));
      end
    end
  end

  task automatic idle();
    bus.issue_valid     = 1'b0;
    bus.issue_rs1       = '0;
    bus.issue_rs2       = '0;
    bus.issue_rd        = '0;
    bus.issue_uses_rs1  = 1'b0;
    bus.issue_uses_rs2  = 1'b0;
    bus.issue_writes_rd = 1'b0;
    bus.wb_valid        = 1'b0;
    bus.wb_rd           = '0;
    flush               = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic offer(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic w);
    bus.issue_valid     = 1'b1;
    bus.issue_rs1       = rs1;
    bus.issue_uses_rs1  = u1;
    bus.issue_rs2       = rs2;
    bus.issue_uses_rs2  = u2;
    bus.issue_rd        = rd;
    bus.issue_writes_rd = w;
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
  endtask

  task automatic expect_state(input string name, input logic rdy, input scoreboard_stall_t sc,
                              input logic [31:0] busy, input int unsigned outst, input logic err);
    exp_t e;
    e.cyc   = cyc;
    e.name  = name;
    e.ready = rdy;
    e.stall = sc;
    e.busy  = busy;
    e.outst = outst;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [31:0] fill_busy;
    idle();
    next_cycle();
    expect_state("in_reset", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    expect_state("reset", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);

    // RAW on x5, released by writeback
    next_cycle(); offer(0, 0, 0, 0, 5, 1);
    expect_state("raw_issue", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle(); offer(5, 1, 0, 0, 0, 0);
    expect_state("raw_stall", 1'b0, STALL_RAW, 32'h20, 1, 1'b0);
    next_cycle(); offer(5, 1, 0, 0, 0, 0); wb(5);
`ifdef REG_FILE_SCOREBOARD_WB_BYPASS_EN
    expect_state("raw_bypass", 1'b1, STALL_NONE, 32'h20, 1, 1'b0);
`else
    expect_state("raw_bubble", 1'b0, STALL_RAW, 32'h20, 1, 1'b0);
`endif
    next_cycle(); offer(5, 1, 0, 0, 0, 0);
    expect_state("raw_release", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);

    // WAW on x9
    next_cycle(); offer(0, 0, 0, 0, 9, 1);
    expect_state("waw_issue", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle(); offer(0, 0, 0, 0, 9, 1);
    expect_state("waw_stall", 1'b0, STALL_WAW, 32'h200, 1, 1'b0);
    next_cycle(); wb(9);
    expect_state("waw_wb", 1'b1, STALL_NONE, 32'h200, 1, 1'b0);
    next_cycle();
    expect_state("waw_clear", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);

    // Fill to MAX_OUTSTANDING with x1..x4
    fill_busy = 32'h0;
    for (int r = 1; r <= 4; r++) begin
      next_cycle(); offer(0, 0, 0, 0, 5'(r), 1);
      expect_state("full_fill", 1'b1, STALL_NONE, fill_busy, r - 1, 1'b0);
      fill_busy[r] = 1'b1;
    end
    next_cycle(); offer(1, 1, 0, 0, 6, 1);
    expect_state("full_over_raw", 1'b0, STALL_FULL, 32'h1E, 4, 1'b0);
    next_cycle(); offer(0, 0, 0, 0, 6, 1); wb(2);
`ifdef REG_FILE_SCOREBOARD_WB_BYPASS_EN
    expect_state("full_bypass", 1'b1, STALL_NONE, 32'h1E, 4, 1'b0);
    next_cycle();
    expect_state("full_after", 1'b1, STALL_NONE, 32'h5A, 4, 1'b0);
`else
    expect_state("full_bubble", 1'b0, STALL_FULL, 32'h1E, 4, 1'b0);
    next_cycle(); offer(0, 0, 0, 0, 6, 1);
    expect_state("full_accept", 1'b1, STALL_NONE, 32'h1A, 3, 1'b0);
`endif
    next_cycle();
    expect_state("full_end", 1'b1, STALL_NONE, 32'h5A, 4, 1'b0);

    // Flush overrides simultaneous issue and writeback
    next_cycle(); flush = 1'b1; offer(0, 0, 0, 0, 9, 1); wb(3);
`ifdef REG_FILE_SCOREBOARD_WB_BYPASS_EN
    expect_state("flush_busy", 1'b0, STALL_NONE, 32'h5A, 4, 1'b0);
`else
    expect_state("flush_busy", 1'b0, STALL_FULL, 32'h5A, 4, 1'b0);
`endif
    next_cycle();
    expect_state("flush_clear", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle(); flush = 1'b1; offer(0, 0, 0, 0, 9, 1);
    expect_state("flush_only", 1'b0, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle();
    expect_state("flush_drop", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);

    // RAW beats WAW, rs2 path, plain WAW
    next_cycle(); offer(0, 0, 0, 0, 3, 1);
    expect_state("prio_issue", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle(); offer(3, 1, 0, 0, 3, 1);
    expect_state("raw_over_waw", 1'b0, STALL_RAW, 32'h8, 1, 1'b0);
    next_cycle(); offer(0, 0, 3, 1, 0, 0);
    expect_state("raw_rs2", 1'b0, STALL_RAW, 32'h8, 1, 1'b0);
    next_cycle(); offer(0, 0, 0, 0, 3, 1);
    expect_state("waw_only", 1'b0, STALL_WAW, 32'h8, 1, 1'b0);
    next_cycle(); wb(3);
    expect_state("prio_wb", 1'b1, STALL_NONE, 32'h8, 1, 1'b0);
    next_cycle();
    expect_state("prio_clear", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);

    // x0 destination and sources never tracked
    for (int i = 0; i < 3; i++) begin
      next_cycle(); offer(0, 1, 0, 1, 0, 1);
      expect_state("x0_issue", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    end
    next_cycle();
    expect_state("x0_idle", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);

    // Stray writeback sets sticky wb_err; then build busy_vec=0xA2
    next_cycle(); wb(12);
    expect_state("wberr_pre", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle(); offer(0, 0, 0, 0, 7, 1);
    expect_state("wberr_set", 1'b1, STALL_NONE, 32'h0, 0, 1'b1);
    next_cycle(); wb(0);
    expect_state("wberr_hold", 1'b1, STALL_NONE, 32'h80, 1, 1'b1);
    next_cycle(); offer(0, 0, 0, 0, 5, 1);
    expect_state("wberr_x0", 1'b1, STALL_NONE, 32'h80, 1, 1'b1);
    next_cycle(); offer(0, 0, 0, 0, 1, 1);
    expect_state("build_a0", 1'b1, STALL_NONE, 32'hA0, 2, 1'b1);
    next_cycle();
    expect_state("busy_a2", 1'b1, STALL_NONE, 32'hA2, 3, 1'b1);

    // Asynchronous reset mid-cycle, then stale writeback
    next_cycle(); rst_n = 1'b0;
    expect_state("async_rst", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle(); rst_n = 1'b1; wb(5);
    expect_state("post_rst_wb", 1'b1, STALL_NONE, 32'h0, 0, 1'b0);
    next_cycle();
    expect_state("post_rst_err", 1'b1, STALL_NONE, 32'h0, 0, 1'b1);

    // Same-cycle set and clear on different registers
    next_cycle(); offer(0, 0, 0, 0, 2, 1);
    expect_state("dual_issue", 1'b1, STALL_NONE, 32'h0, 0, 1'b1);
    next_cycle(); offer(0, 0, 0, 0, 4, 1); wb(2);
    expect_state("dual_both", 1'b1, STALL_NONE, 32'h4, 1, 1'b1);
    next_cycle();
    expect_state("dual_after", 1'b1, STALL_NONE, 32'h10, 1, 1'b1);
`ifdef REG_FILE_SCOREBOARD_WB_BYPASS_EN
    next_cycle(); offer(0, 0, 0, 0, 4, 1); wb(4);
    expect_state("same_reg", 1'b1, STALL_NONE, 32'h10, 1, 1'b1);
    next_cycle();
    expect_state("same_reg_after", 1'b1, STALL_NONE, 32'h10, 1, 1'b1);
`endif

    next_cycle();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, max in-flight register-writing instructions (1..31).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port issue_valid  input  1  decode offers an instruction.
REQ-005 SHALL have port issue_ready  output  1  scoreboard accepts the offered instruction.
REQ-006 SHALL have ports issue_rs1, issue_rs2, issue_rd  input  5 each  register addresses from decode.
REQ-007 SHALL have ports issue_uses_rs1, issue_uses_rs2, issue_writes_rd  input  1 each  operand/destination usage flags.
REQ-008 SHALL have ports wb_valid  input  1 and wb_rd  input  5  writeback completion.
REQ-009 SHALL have port flush  input  1  pipeline flush; discards all pending writes.
REQ-010 SHALL have port busy_vec  output  32  per-register pending-write bits; bit 0 always 0.
REQ-011 SHALL have port outstanding  output  $clog2(MAX_OUTSTANDING+1)  count of set busy bits.
REQ-012 SHALL have port stall_cause  output  scoreboard_stall_t (2)  NONE/RAW/WAW/FULL, priority FULL > RAW > WAW.
REQ-013 SHALL have port wb_err  output  1  sticky: writeback to non-busy register seen.

Function
REQ-014 Accept = issue_valid & issue_ready; no state changes on an offer without accept.
REQ-015 issue_ready combinational: low if flush, RAW (uses_rsN & busy[rsN]), WAW (writes_rd & busy[rd]), or FULL (writes_rd & rd!=0 & outstanding==MAX_OUTSTANDING).
REQ-016 Address 0 never busy, never hazards, never counted; writes_rd with rd=0 accepts without state change.
REQ-017 Accept with writes_rd, rd!=0: busy[rd] set and outstanding +1, visible next cycle (1-cycle latency).
REQ-018 wb_valid with busy[wb_rd]=1: busy[wb_rd] cleared, outstanding -1, next cycle.
REQ-019 wb_valid with busy[wb_rd]=0 or wb_rd=0: no state change; wb_err set next cycle, held until reset.
REQ-020 Same-cycle accept-set and writeback-clear on different registers: both apply, outstanding unchanged.
REQ-021 Same-cycle set and clear on same register (bypass build only): register ends busy, outstanding unchanged.
REQ-022 flush: next cycle busy_vec=0, outstanding=0; overrides same-cycle accept and writeback; wb_err unaffected.
REQ-023 outstanding SHALL always equal popcount(busy_vec); never exceeds MAX_OUTSTANDING, never underflows.
REQ-024 stall_cause=NONE whenever issue_valid=0 or issue_ready=1; flush-only stall reports NONE.

Reset
REQ-025 rst_n low asynchronously forces busy_vec=0, outstanding=0, wb_err=0; stall_cause/issue_ready follow combinationally.
REQ-026 Reset mid-operation discards all pending state; writebacks after release for pre-reset issues raise wb_err.

Configuration
REQ-027 Macro REG_FILE_SCOREBOARD_WB_BYPASS_EN defined: hazard/FULL checks use busy_vec with the current-cycle valid writeback's bit cleared (and count decremented), zero-bubble issue.
REQ-028 Macro undefined: hazard/FULL checks use registered busy_vec/outstanding only; one-cycle bubble after writeback; REQ-021 unreachable.

Structure
REQ-029 scoreboard_stall_t and REG_ADDR_W (5) SHALL live in reg_file_pkg; REGISTER_X0 reused from existing shared definitions.
REQ-030 Hazard evaluation SHALL be one combinational sub-module, scoreboard_hazard_check; state update stays in reg_file_scoreboard.

Verification
REQ-031 Issue rd=5, next cycle issue rs1=5 -> issue_ready=0, stall_cause=RAW; wb_rd=5 -> accepted same cycle (bypass) or next cycle (no bypass).
REQ-032 MAX_OUTSTANDING=4, issue rd=1..4, then rd=6 -> stall_cause=FULL, outstanding=4; wb_rd=2 -> rd=6 accepted, outstanding stays 4.
REQ-033 Issue rd=0 with rs1=0 repeatedly -> always accepted, busy_vec=0, outstanding=0.
REQ-034 busy rd=3,7; flush with simultaneous issue rd=9 and wb_rd=3 -> next cycle busy_vec=0, outstanding=0.
REQ-035 wb_rd=12 while not busy -> wb_err=1, held across later traffic until rst_n low.
REQ-036 rst_n asserted asynchronously with busy_vec=0x0000_00A2 -> outputs zero before next clk edge.
